// File: rtl/hv_reg_pkg.sv
// Shared types and CRC-8 helper for the hv register-bank responder.
package hv_reg_pkg;

  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam logic [7:0] CRC8_INIT  = 8'hFF;
  localparam logic [7:0] UNLOCK_KEY = 8'h5A;

  typedef enum logic [1:0] {
    IDLE,
    CHK,
    RSP
  } rsp_st_e;

  // MSB-first CRC-8 over one data byte
  function automatic logic [7:0] crc8_calc(input logic [7:0] data);
    logic [7:0] c;
    c = CRC8_INIT;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/hv_reg_bank_rsp.sv
// Register-bank responder: CRC-checked writes, CRC-tagged reads, 2-cycle ack.
// Optional write protection of the upper bank via HV_REG_WR_LOCK_EN.
module hv_reg_bank_rsp
  import hv_reg_pkg::*;
#(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int REG_NUM   = 32,
  parameter int PROT_BASE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rac_reg_ren,
  input  logic                      i_rac_reg_wen,
  input  logic [REG_AW-1:0]         i_rac_reg_addr,
  input  logic [REG_DW-1:0]         i_rac_reg_wdata,
  input  logic [REG_CRC_W-1:0]      i_rac_reg_wcrc,
  output logic                      o_reg_rac_wack,
  output logic                      o_reg_rac_rack,
  output logic [REG_DW-1:0]         o_reg_rac_rdata,
  output logic [REG_CRC_W-1:0]      o_reg_rac_rcrc,
  output logic [REG_NUM*REG_DW-1:0] o_reg_q,
  output logic                      o_wcrc_err,
  output logic                      o_addr_err,
  input  logic                      i_err_clr
);

  localparam int IW = $clog2(REG_NUM);

  rsp_st_e st_q, st_d;

  logic                 wr_q;
  logic [REG_AW-1:0]    addr_q;
  logic [REG_DW-1:0]    wdata_q;
  logic [REG_CRC_W-1:0] wcrc_q;
  logic                 crc_bad_q, oor_q, lock_q;
  logic [REG_DW-1:0]    regs_q [REG_NUM];
  logic [REG_DW-1:0]    rdata_q;
  logic [REG_CRC_W-1:0] rcrc_q;
  logic                 wcrc_err_q, wcrc_err_d;
  logic                 addr_err_q, addr_err_d;

  logic              req;
  logic              oor_c, crc_bad_c, lock_c;
  logic              commit;
  logic [IW-1:0]     idx;
  logic [REG_DW-1:0] rd_c;

  assign req       = i_rac_reg_ren | i_rac_reg_wen;
  assign idx       = addr_q[IW-1:0];
  assign oor_c     = addr_q >= REG_AW'(REG_NUM);
  assign crc_bad_c = crc8_calc(wdata_q) != wcrc_q;
  assign rd_c      = oor_c ? '0 : regs_q[idx];

`ifdef HV_REG_WR_LOCK_EN
  // key register is outside the protected window, so it stays writable
  assign lock_c = (addr_q >= REG_AW'(PROT_BASE))
                & (addr_q <= REG_AW'(REG_NUM-2))
                & (regs_q[REG_NUM-1] != UNLOCK_KEY);
`else
  assign lock_c = 1'b0;
`endif

  assign commit = (st_q == RSP) & wr_q & ~crc_bad_q & ~oor_q & ~lock_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (req) st_d = CHK;
      CHK:     st_d = RSP;
      RSP:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    o_reg_rac_wack = 1'b0;
    o_reg_rac_rack = 1'b0;
    if (st_q == RSP) begin
      o_reg_rac_wack = wr_q;
      o_reg_rac_rack = ~wr_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wcrc_q    <= '0;
      crc_bad_q <= 1'b0;
      oor_q     <= 1'b0;
      lock_q    <= 1'b0;
      rdata_q   <= '0;
      rcrc_q    <= '0;
      for (int n = 0; n < REG_NUM; n++) regs_q[n] <= '0;
    end else begin
      if (st_q == IDLE && req) begin
        wr_q    <= i_rac_reg_wen;
        addr_q  <= i_rac_reg_addr;
        wdata_q <= i_rac_reg_wdata;
        wcrc_q  <= i_rac_reg_wcrc;
      end
      if (st_q == CHK) begin
        crc_bad_q <= wr_q & crc_bad_c;
        oor_q     <= oor_c;
        lock_q    <= wr_q & lock_c;
        if (!wr_q) begin
          rdata_q <= rd_c;
          rcrc_q  <= crc8_calc(rd_c);
        end
      end
      if (commit) regs_q[idx] <= wdata_q;
    end
  end

  // a same-cycle set beats the clear
  always_comb begin
    wcrc_err_d = wcrc_err_q & ~i_err_clr;
    addr_err_d = addr_err_q & ~i_err_clr;
    if (st_q == RSP) begin
      wcrc_err_d = wcrc_err_d | crc_bad_q;
      addr_err_d = addr_err_d | oor_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wcrc_err_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      wcrc_err_q <= wcrc_err_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    o_reg_q = '0;
    for (int n = 0; n < REG_NUM; n++) o_reg_q[n*REG_DW +: REG_DW] = regs_q[n];
  end

  assign o_reg_rac_rdata = rdata_q;
  assign o_reg_rac_rcrc  = rcrc_q;
  assign o_wcrc_err      = wcrc_err_q;
  assign o_addr_err      = addr_err_q;

  a_one_in_flight: assert property (
    @(posedge i_clk) disable iff (i_rst) (st_q != IDLE) |-> !req
  );

endmodule

// File: tb/tb_hv_reg_bank_rsp.sv
// Directed scoreboard bench for hv_reg_bank_rsp.
// Lock checks follow HV_REG_WR_LOCK_EN when defined.
module tb_hv_reg_bank_rsp;

  logic         clk = 1'b0;
  logic         rst;
  logic         ren, wen, err_clr;
  logic [6:0]   addr;
  logic [7:0]   wdata, wcrc;
  logic         wack, rack;
  logic [7:0]   rdata, rcrc;
  logic [255:0] reg_q;
  logic         wcrc_err, addr_err;

  hv_reg_bank_rsp dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rac_reg_ren   (ren),
    .i_rac_reg_wen   (wen),
    .i_rac_reg_addr  (addr),
    .i_rac_reg_wdata (wdata),
    .i_rac_reg_wcrc  (wcrc),
    .o_reg_rac_wack  (wack),
    .o_reg_rac_rack  (rack),
    .o_reg_rac_rdata (rdata),
    .o_reg_rac_rcrc  (rcrc),
    .o_reg_q         (reg_q),
    .o_wcrc_err      (wcrc_err),
    .o_addr_err      (addr_err),
    .i_err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [7:0]  rd;
    logic [7:0]  crc;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc     = 0;
  int          n_chk   = 0;
  int          n_fail  = 0;
  int          ack_cnt = 0;
  logic [7:0]  m [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] model_q();
    logic [255:0] v;
    for (int n = 0; n < 32; n++) v[n*8 +: 8] = m[n];
    return v;
  endfunction

  // monitor: pops one expectation per ack, flags late or unexpected acks
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
        e = sbq.pop_front();
        chk("ack_timeout", 256'(cyc), 256'(e.cyc));
      end
      if (wack || rack) begin
        ack_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {254'd0, wack, rack}, 256'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_kind", {254'd0, wack, rack}, e.wr ? 256'd2 : 256'd1);
          chk("ack_cycle", 256'(cyc), 256'(e.cyc));
          if (!e.wr) begin
            chk("rdata", 256'(rdata), 256'(e.rd));
            chk("rcrc", 256'(rcrc), 256'(e.crc));
          end
        end
      end
    end
  end

  task automatic req(input bit w, input bit r, input logic [6:0] a,
                     input logic [7:0] d, input logic [7:0] c,
                     input logic [7:0] er, input logic [7:0] ec,
                     input bit clr_rsp);
    @(negedge clk);
    wen = w; ren = r; addr = a; wdata = d; wcrc = c;
    sbq.push_back('{w, er, ec, cyc + 2});
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    @(negedge clk);
    if (clr_rsp) err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d,
                    input logic [7:0] c);
    req(1'b1, 1'b0, a, d, c, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] er,
                    input logic [7:0] ec);
    req(1'b0, 1'b1, a, 8'h00, 8'h00, er, ec, 1'b0);
  endtask

  task automatic clr_pulse();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int n = 0; n < 32; n++) m[n] = 8'h00;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; err_clr = 1'b0;
    addr = '0; wdata = '0; wcrc = '0;
    repeat (3) @(negedge clk);
    chk("rst_acks", {254'd0, wack, rack}, 256'd0);
    chk("rst_rd", {240'd0, rdata, rcrc}, 256'd0);
    chk("rst_flags", {254'd0, wcrc_err, addr_err}, 256'd0);
    chk("rst_regs", reg_q, 256'd0);
    rst = 1'b0;

    rd(7'd3, 8'h00, 8'hF3);
    chk("rd3_addr_err", 256'(addr_err), 256'd0);

    wr(7'd5, 8'hA5, 8'h81);
    m[5] = 8'hA5;
    chk("wr5_slice", 256'(reg_q[47:40]), 256'hA5);
    chk("wr5_regs", reg_q, model_q());
    rd(7'd5, 8'hA5, 8'h81);

    wr(7'd5, 8'h3C, 8'h00);
    chk("badcrc_regs", reg_q, model_q());
    chk("badcrc_flag", 256'(wcrc_err), 256'd1);
    chk("badcrc_addr_flag", 256'(addr_err), 256'd0);
    clr_pulse();
    chk("wcrc_clr", 256'(wcrc_err), 256'd0);

    rd(7'd40, 8'h00, 8'hF3);
    chk("rd40_addr_err", 256'(addr_err), 256'd1);
    clr_pulse();
    chk("addr_clr", 256'(addr_err), 256'd0);

    req(1'b1, 1'b0, 7'd40, 8'hA5, 8'h81, 8'h00, 8'h00, 1'b1);
    chk("wr40_regs", reg_q, model_q());
    chk("wr40_set_wins", 256'(addr_err), 256'd1);
    chk("wr40_wcrc_flag", 256'(wcrc_err), 256'd0);
    clr_pulse();

    req(1'b1, 1'b1, 7'd2, 8'h11, 8'h84, 8'h00, 8'h00, 1'b0);
    m[2] = 8'h11;
    chk("rw2_regs", reg_q, model_q());
    rd(7'd2, 8'h11, 8'h84);

    wr(7'd20, 8'h77, 8'hB1);
`ifndef HV_REG_WR_LOCK_EN
    m[20] = 8'h77;
`endif
    chk("wr20_first", reg_q, model_q());
    chk("wr20_flags", {254'd0, wcrc_err, addr_err}, 256'd0);
    wr(7'd31, 8'h5A, 8'h72);
    m[31] = 8'h5A;
    wr(7'd20, 8'h77, 8'hB1);
    m[20] = 8'h77;
    chk("wr20_unlocked", reg_q, model_q());
    rd(7'd31, 8'h5A, 8'h72);

    base = ack_cnt;
    @(negedge clk);
    wen = 1'b1; addr = 7'd7; wdata = 8'hA5; wcrc = 8'h81;
    @(negedge clk);
    wen = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_ack", 256'(ack_cnt), 256'(base));
    chk("midrst_regs", reg_q, 256'd0);
    chk("midrst_queue", 256'(sbq.size()), 256'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
